vit_frame_sequencer: RTL
========================

// Module: vit_frame_sequencer
// PURPOSE
//  Front-end scheduler for the (2,1,3) Viterbi decoder core (control/ACS/traceback units).
//  - Accepts received n-bit symbols from an upstream buffer over a valid/ready handshake.
//  - Paces them into the core one symbol at a time, never during a traceback/output phase.
//  - Appends M zero tail symbols per frame, counts decoded bits out of the core, and closes the frame.
//  - On out-of-sync error: resets the core and discards the rest of the frame.
// PARAMETERS
//  N          2    symbol width (code outputs per info bit)
//  M          2    encoder memory; number of tail symbols appended per frame
//  BLOCK_LEN  256  info bits per frame (data symbols accepted before tail)
//  CNT_W      9    width of symbol/bit counters; must satisfy 2^CNT_W > BLOCK_LEN+M
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  frame_start in   1      1-cycle pulse: begin new frame; honoured in IDLE or RESYNC only
//  sym_in      in   N      received symbol from upstream
//  sym_valid   in   1      sym_in valid
//  sym_ready   out  1      sequencer accepts sym_in this cycle (transfer = valid & ready)
//  sym_out     out  N      symbol to core branch-metric input (registered)
//  sym_stb     out  1      1-cycle strobe: core consumes sym_out
//  tb_en       in   1      core traceback-active flag
//  dx_oe       in   1      core decoded-bit output enable
//  dx          in   1      core decoded bit (valid when dx_oe)
//  error       in   1      core out-of-sync error flag
//  dec_rst     out  1      synchronous reset request to core (OR'd with system reset upstream)
//  bit_out     out  1      decoded bit, registered copy of dx
//  bit_valid   out  1      1-cycle; bit_out valid
//  frame_done  out  1      1-cycle pulse: frame fully decoded
//  sync_lost   out  1      sticky; set by error, cleared by next accepted frame_start
//  busy        out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: sym_out, sym_stb, sym_ready, dec_rst, bit_out, bit_valid,
//   frame_done, sync_lost, busy. Counters sym_cnt=0, bit_cnt=0.
//  States: IDLE, CLEAR, FEED, GUARD, HOLD, TAIL, DRAIN, DONE, RESYNC.
//  IDLE: frame_start -> CLEAR; sync_lost<=0.
//  CLEAR: dec_rst=1 for exactly 1 cycle, then FEED. Counters cleared.
//  FEED: sym_ready = (!tb_en && !dx_oe && sym_cnt<BLOCK_LEN), combinational.
//   On transfer: next cycle sym_out=sym_in and sym_stb=1 (latency 1); sym_cnt++; go GUARD.
//   If sym_cnt==BLOCK_LEN: no handshake; go TAIL.
//  GUARD: 1 cycle, sym_ready=0. Then if tb_en=1 -> HOLD, else -> FEED (or TAIL if sym_cnt>=BLOCK_LEN).
//  HOLD: sym_ready=0; wait for the dx_oe=1 cycle. The cycle after dx_oe falls:
//   -> FEED if sym_cnt<BLOCK_LEN, TAIL if sym_cnt<BLOCK_LEN+M, else DRAIN.
//  TAIL: issues sym_out=0, sym_stb=1 for one cycle, sym_cnt++, -> GUARD.
//   Tail symbols use the same pacing as data; M tail strobes total.
//  DRAIN: no strobes; collect remaining dx_oe bits until bit_cnt==BLOCK_LEN -> DONE.
//  Bit capture (FEED..DRAIN): each dx_oe=1 cycle -> bit_out<=dx, bit_valid<=1 next cycle,
//   bit_cnt++. Bits beyond BLOCK_LEN (tail bits) are dropped: no bit_valid.
//  DONE: frame_done=1 and dec_rst=1 for 1 cycle -> IDLE.
//  Error: error=1 in any state FEED..DRAIN -> RESYNC with sync_lost<=1.
//   Error takes priority over a simultaneous transfer or dx_oe (neither takes effect).
//  RESYNC: dec_rst=1 continuously; sym_ready=1; accepted symbols discarded (no sym_stb);
//   frame_start -> CLEAR (sync_lost cleared).
//  Other events: frame_start outside IDLE/RESYNC is ignored. sym_cnt saturates at BLOCK_LEN+M.
//   No counter wraps within a frame.
//  Asynchronous reset mid-frame: immediate return to reset values; partial frame lost, no frame_done.
// TESTING
//  1 Reset asserted mid-FEED -> all outputs 0 same cycle, state IDLE; frame_start then gives 1 dec_rst pulse.
//  2 BLOCK_LEN=8, M=2, stub core (tb_en 3 cycles, dx_oe 1 cycle after each strobe) -> exactly 10 sym_stb
//    (last 2 with sym_out=0), 8 bit_valid, 1 frame_done.
//  3 sym_valid held 1 while tb_en=1 -> sym_ready=0 every cycle; no transfer until cycle after dx_oe falls.
//  4 sym_valid toggling 1/0 -> each sym_stb 1 cycle after its transfer, sym_out equals accepted sym_in, order kept.
//  5 error pulse on symbol 5 coincident with dx_oe -> no bit_valid that cycle; sync_lost=1; dec_rst held;
//    later symbols accepted with no sym_stb; next frame_start clears sync_lost.
//  6 frame_start pulsed during FEED and DRAIN -> ignored; sym_cnt/bit_cnt unchanged; frame completes normally.

Source files
------------

// File: rtl/vit_frame_sequencer.sv
// Front-end scheduler for the (2,1,3) Viterbi core: paces received symbols into the core,
// appends the zero tail, collects decoded bits and recovers from loss of sync.
module vit_frame_sequencer #(
   parameter int unsigned N         = 2,
   parameter int unsigned M         = 2,
   parameter int unsigned BLOCK_LEN = 256,
   parameter int unsigned CNT_W     = 9
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         frame_start,
   input  logic [N-1:0] sym_in,
   input  logic         sym_valid,
   output logic         sym_ready,
   output logic [N-1:0] sym_out,
   output logic         sym_stb,
   input  logic         tb_en,
   input  logic         dx_oe,
   input  logic         dx,
   input  logic         error,
   output logic         dec_rst,
   output logic         bit_out,
   output logic         bit_valid,
   output logic         frame_done,
   output logic         sync_lost,
   output logic         busy
);

   localparam int unsigned FRAME_SYMS = BLOCK_LEN + M;
   localparam logic [CNT_W-1:0] DATA_LIM  = CNT_W'(BLOCK_LEN);
   localparam logic [CNT_W-1:0] FRAME_LIM = CNT_W'(FRAME_SYMS);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_FEED, S_GUARD, S_HOLD, S_TAIL, S_DRAIN, S_DONE, S_RESYNC
   } state_t;

   state_t           state;
   state_t           resume_state;
   logic [CNT_W-1:0] sym_cnt;
   logic [CNT_W-1:0] bit_cnt;
   logic             in_frame;

   assign in_frame  = state inside {S_FEED, S_GUARD, S_HOLD, S_TAIL, S_DRAIN};
   assign sym_ready = (state == S_RESYNC) ||
                      ((state == S_FEED) && !tb_en && !dx_oe && (sym_cnt < DATA_LIM));

   // Where to continue once the core is ready for another symbol.
   always_comb begin
      resume_state = S_DRAIN;
      if (sym_cnt < DATA_LIM) begin
         resume_state = S_FEED;
      end else if (sym_cnt < FRAME_LIM) begin
         resume_state = S_TAIL;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         sym_cnt    <= '0;
         bit_cnt    <= '0;
         sym_out    <= '0;
         sym_stb    <= 1'b0;
         dec_rst    <= 1'b0;
         bit_out    <= 1'b0;
         bit_valid  <= 1'b0;
         frame_done <= 1'b0;
         sync_lost  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         sym_stb    <= 1'b0;
         bit_valid  <= 1'b0;
         frame_done <= 1'b0;
         // Loss of sync overrides any handshake or bit capture in the same cycle.
         if (in_frame && error) begin
            state     <= S_RESYNC;
            sync_lost <= 1'b1;
            dec_rst   <= 1'b1;
         end else begin
            if (in_frame && dx_oe && (bit_cnt < DATA_LIM)) begin
               bit_out   <= dx;
               bit_valid <= 1'b1;
               bit_cnt   <= bit_cnt + CNT_W'(1);
            end
            case (state)
               S_IDLE: begin
                  if (frame_start) begin
                     state     <= S_CLEAR;
                     sync_lost <= 1'b0;
                     dec_rst   <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
               S_CLEAR: begin
                  dec_rst <= 1'b0;
                  sym_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= S_FEED;
               end
               S_FEED: begin
                  if (sym_cnt >= DATA_LIM) begin
                     state <= S_TAIL;
                  end else if (sym_valid && sym_ready) begin
                     sym_out <= sym_in;
                     sym_stb <= 1'b1;
                     sym_cnt <= sym_cnt + CNT_W'(1);
                     state   <= S_GUARD;
                  end
               end
               S_GUARD: begin
                  state <= tb_en ? S_HOLD : resume_state;
               end
               S_HOLD: begin
                  if (dx_oe) begin
                     state <= resume_state;
                  end
               end
               S_TAIL: begin
                  sym_out <= '0;
                  sym_stb <= 1'b1;
                  if (sym_cnt < FRAME_LIM) begin
                     sym_cnt <= sym_cnt + CNT_W'(1);
                  end
                  state <= S_GUARD;
               end
               S_DRAIN: begin
                  if (bit_cnt >= DATA_LIM) begin
                     state      <= S_DONE;
                     frame_done <= 1'b1;
                     dec_rst    <= 1'b1;
                  end
               end
               S_DONE: begin
                  dec_rst <= 1'b0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
               S_RESYNC: begin
                  // Core held in reset; incoming symbols are drained and dropped.
                  if (frame_start) begin
                     state     <= S_CLEAR;
                     sync_lost <= 1'b0;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
